ntt_zeta_sched: RTL

Schedules twiddle-factor reads from the per-stage zeta ROM bank for the pipelined NTT/INTT datapath. Each stage streams two butterflies (lanes 0/1) per cycle. On start, the block generates the per-stage, per-lane ROM addresses, skewed by the butterfly pipeline latency. It emits a valid strobe aligned with the 1-cycle ROM read data and pulses done after the last stage's final zeta is delivered. Back-to-back polynomials are supported with zero bubble.

---
 rtl/ntt_pkg.sv | 30 +++
 rtl/ntt_stage_addr_cnt.sv | 90 +++++++++
 rtl/ntt_zeta_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT twiddle-factor address scheduler.
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 8
`endif

package ntt_pkg;

  localparam int STAGE_CNT_DEF = `NTT_STAGE_CNT;

  typedef enum logic {
    MODE_NTT  = 1'b0,
    MODE_INTT = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Issue cycles per stage per polynomial: two butterflies per cycle.
  function automatic int cyc_of(input int stage_cnt);
    return 1 << (stage_cnt - 2);
  endfunction

  function automatic int addr_w_of(input int stage_cnt);
    return stage_cnt - 1;
  endfunction

endpackage

// File: rtl/ntt_stage_addr_cnt.sv
// One NTT stage: butterfly counter, mode latch, per-lane zeta address and
// the one-cycle valid delay that lines up with the ROM read data.
module ntt_stage_addr_cnt
  import ntt_pkg::*;
#(
  parameter int STAGE_CNT = STAGE_CNT_DEF,
  parameter int STAGE     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      tok_valid,
  input  mode_e                     tok_mode,
  output logic                      active,
  output logic [1:0][STAGE_CNT-2:0] addr,
  output logic                      zeta_valid,
  output logic                      last_valid
);

  localparam int                  CYC        = cyc_of(STAGE_CNT);
  localparam int                  ADDR_W     = addr_w_of(STAGE_CNT);
  localparam int                  CNT_W      = ADDR_W - 1;
  localparam int                  SHIFT      = ADDR_W - STAGE;
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(CYC - 1);
  localparam logic [ADDR_W-1:0]   STAGE_MASK = ADDR_W'((1 << STAGE) - 1);

  logic                   active_q, active_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  mode_e                  mode_q, mode_d;
  logic [1:0][ADDR_W-1:0] addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;

  // Butterfly b = {c, lane}; its top STAGE bits select the twiddle (stage 0 -> 0).
  function automatic logic [ADDR_W-1:0] zeta_addr(input logic [CNT_W-1:0] c,
                                                  input logic lane,
                                                  input mode_e m);
    logic [ADDR_W-1:0] fwd;
    fwd = {c, lane} >> SHIFT;
    return (m == MODE_INTT) ? (STAGE_MASK - fwd) : fwd;
  endfunction

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    last_d   = last_q;
    if (!stall) begin
      valid_d = active_q;
      last_d  = active_q && (cnt_q == CNT_LAST);
      if (tok_valid) begin
        active_d = 1'b1;
        cnt_d    = '0;
        mode_d   = tok_mode;
      end else if (active_q) begin
        if (cnt_q == CNT_LAST) active_d = 1'b0;
        else                   cnt_d    = cnt_q + 1'b1;
      end
      if (active_d) begin
        for (int l = 0; l < 2; l++) addr_d[l] = zeta_addr(cnt_d, l[0], mode_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= MODE_NTT;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign active     = active_q;
  assign addr       = addr_q;
  assign zeta_valid = valid_q & ~stall;
  assign last_valid = last_q & ~stall;

endmodule

// File: rtl/ntt_zeta_sched.sv
// Twiddle ROM address scheduler: accepts polynomials, skews a start token
// down the stages by BF_LAT cycles each, and signals completion.
module ntt_zeta_sched
  import ntt_pkg::*;
#(
  parameter int STAGE_CNT = STAGE_CNT_DEF,
  parameter int BF_LAT    = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic                                      mode,
  input  logic                                      stall,
  output logic                                      start_ready,
  output logic                                      busy,
  output logic [1:0][STAGE_CNT-1:0][STAGE_CNT-2:0]  rom_addr,
  output logic [STAGE_CNT-1:0]                      zeta_valid,
  output logic                                      done
);

  localparam int               CYC       = cyc_of(STAGE_CNT);
  localparam int               CNT_W     = STAGE_CNT - 2;
  localparam int               CHAIN_LEN = (STAGE_CNT - 1) * BF_LAT;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYC - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     run_cnt_q, run_cnt_d;
  logic                 start_ready_q, start_ready_d;
  logic [CHAIN_LEN-1:0] tok_v_q, tok_v_d;
  logic [CHAIN_LEN-1:0] tok_m_q, tok_m_d;
  logic                 accept;
  logic [STAGE_CNT-1:0] tap_v, tap_m, stage_active, stage_last;
  logic                 unused_last;

  assign accept      = start && start_ready_q && !stall;
  assign busy        = (|stage_active) || (|tok_v_q);
  assign start_ready = start_ready_q;
  assign done        = stage_last[STAGE_CNT-1];
  assign unused_last = ^stage_last[STAGE_CNT-2:0];

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    tok_v_d   = tok_v_q;
    tok_m_d   = tok_m_q;
    if (!stall) begin
      tok_v_d = {tok_v_q[CHAIN_LEN-2:0], accept};
      tok_m_d = {tok_m_q[CHAIN_LEN-2:0], mode};
      case (state_q)
        ST_IDLE: if (accept) begin
          state_d   = ST_RUN;
          run_cnt_d = '0;
        end
        ST_RUN: begin
          if (run_cnt_q == CNT_LAST) begin
            if (accept) run_cnt_d = '0;
            else        state_d   = ST_DRAIN;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (accept) begin
            state_d   = ST_RUN;
            run_cnt_d = '0;
          end else if (!busy) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Ready is only withheld while stage 0 still has issue slots left.
    start_ready_d = (state_d != ST_RUN) || (run_cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      run_cnt_q     <= '0;
      start_ready_q <= 1'b1;
      tok_v_q       <= '0;
      tok_m_q       <= '0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      start_ready_q <= start_ready_d;
      tok_v_q       <= tok_v_d;
      tok_m_q       <= tok_m_d;
    end
  end

  for (genvar gi = 0; gi < STAGE_CNT; gi++) begin : g_stage
    logic [1:0][STAGE_CNT-2:0] addr_s;

    // Stage s loads one cycle before its first issue, hence tap s*BF_LAT-1.
    if (gi == 0) begin : g_head
      assign tap_v[gi] = accept;
      assign tap_m[gi] = mode;
    end else begin : g_tap
      assign tap_v[gi] = tok_v_q[gi*BF_LAT-1];
      assign tap_m[gi] = tok_m_q[gi*BF_LAT-1];
    end

    ntt_stage_addr_cnt #(
      .STAGE_CNT (STAGE_CNT),
      .STAGE     (gi)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .tok_valid  (tap_v[gi]),
      .tok_mode   (mode_e'(tap_m[gi])),
      .active     (stage_active[gi]),
      .addr       (addr_s),
      .zeta_valid (zeta_valid[gi]),
      .last_valid (stage_last[gi])
    );

    assign rom_addr[0][gi] = addr_s[0];
    assign rom_addr[1][gi] = addr_s[1];
  end

endmodule
